// File: rtl/axis_rgb2gray.sv
// axis_rgb2gray: AXI-Stream RGB888 -> 8-bit luma front end for the histogram stage.
// Two-stage pipeline (products, then sum/shift) with full backpressure and no
// bubbles. Output tlast is regenerated from a W*H pixel counter. Sticky flags
// report source frames whose tlast is early or missing.
// Build option: define RGB2GRAY_ROUND_EN to round half-up (adds 128 before the
// shift); leave it undefined to truncate.
module axis_rgb2gray #(
   parameter int W               = 64,
   parameter int H               = 64,
   parameter int TOTAL_PIXEL     = W * H,
   parameter int TOTAL_PIXEL_BIT = $clog2(W * H)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   input  logic        err_clr,
   output logic        err_early,
   output logic        err_late,
   output logic        frame_done
);

   localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_IDX = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);

`ifdef RGB2GRAY_ROUND_EN
   localparam logic [15:0] RND = 16'd128;
`else
   localparam logic [15:0] RND = 16'd0;
`endif

   // Channel order in the products array: 0 = R, 1 = G, 2 = B.
   logic [7:0]                 chan [3];
   logic [15:0]                prod [3];
   logic [15:0]                sum;

   logic                       v1_reg, last1_reg;
   logic                       v2_reg, last2_reg;
   logic [7:0]                 y_reg;
   logic [TOTAL_PIXEL_BIT-1:0] cnt_reg;
   logic                       err_early_reg, err_late_reg;
   logic                       frame_done_reg;

   logic                       en1, en2;
   logic                       in_hs;
   logic                       at_last_idx;
   logic                       is_last;
   logic                       set_early, set_late;

   assign chan[0] = s_axis_tdata[23:16];
   assign chan[1] = s_axis_tdata[15:8];
   assign chan[2] = s_axis_tdata[7:0];

   // Each stage advances when its output slot is empty or is being drained;
   // the ready chain is combinational from m_axis_tready so a full pipeline
   // still takes a new pixel in the cycle the stall releases.
   assign en2           = !v2_reg || m_axis_tready;
   assign en1           = !v1_reg || en2;
   assign s_axis_tready = en1;
   assign in_hs         = s_axis_tvalid && en1;

   // A source tlast ends the frame early; reaching the last index ends it
   // regardless of tlast, so downstream never sees an over-long frame.
   assign at_last_idx = (cnt_reg == LAST_IDX);
   assign is_last     = at_last_idx || s_axis_tlast;
   assign set_early   = in_hs && s_axis_tlast && !at_last_idx;
   assign set_late    = in_hs && at_last_idx && !s_axis_tlast;

   // Max sum is 255*256 + 128 = 65408, so 16 bits never overflow.
   assign sum = prod[0] + prod[1] + prod[2] + RND;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         localparam logic [7:0] COEF = (gi == 0) ? 8'd77 : ((gi == 1) ? 8'd150 : 8'd29);
         logic [15:0] prod_reg;

         // Stage 1: weighted channel product, loaded whenever stage 1 advances.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               prod_reg <= '0;
            end else if (en1) begin
               prod_reg <= {8'd0, chan[gi]} * {8'd0, COEF};
            end
         end

         assign prod[gi] = prod_reg;
      end
   endgenerate

   // Stage 1 control: valid bit and end-of-frame tag travel with the products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_reg    <= 1'b0;
         last1_reg <= 1'b0;
      end else if (en1) begin
         v1_reg    <= s_axis_tvalid;
         last1_reg <= s_axis_tvalid && is_last;
      end
   end

   // Stage 2: luma, valid and tlast; these registers drive the master port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_reg    <= 1'b0;
         last2_reg <= 1'b0;
         y_reg     <= '0;
      end else if (en2) begin
         v2_reg    <= v1_reg;
         last2_reg <= last1_reg;
         y_reg     <= sum[15:8];
      end
   end

   // Pixel position within the frame; restarts after every frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (in_hs) begin
         cnt_reg <= is_last ? '0 : cnt_reg + TOTAL_PIXEL_BIT'(1);
      end
   end

   // Sticky framing errors; a new violation outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_early_reg <= 1'b0;
         err_late_reg  <= 1'b0;
      end else begin
         if (set_early)    err_early_reg <= 1'b1;
         else if (err_clr) err_early_reg <= 1'b0;
         if (set_late)     err_late_reg  <= 1'b1;
         else if (err_clr) err_late_reg  <= 1'b0;
      end
   end

   // One-cycle pulse after the output beat carrying tlast is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= v2_reg && m_axis_tready && last2_reg;
      end
   end

   assign m_axis_tdata  = y_reg;
   assign m_axis_tvalid = v2_reg;
   assign m_axis_tlast  = last2_reg;
   assign err_early     = err_early_reg;
   assign err_late      = err_late_reg;
   assign frame_done    = frame_done_reg;

endmodule
